// File: rtl/tap_pkg.sv
// ---------------------------------------------------------------------------
// tap_pkg
// Shared definitions for the TAP instruction register:
//   - 4-bit JTAG opcode constants
//   - sel_e : bit index of each instruction inside the one-hot SELECT bus
//   - NUM_INSTR : width of the SELECT bus
//   - sel_onehot() : turns a sel_e index into a one-hot SELECT word
// ---------------------------------------------------------------------------
package tap_pkg;

  localparam int NUM_INSTR = 9;

  localparam logic [3:0] OP_EXTEST   = 4'b0000;
  localparam logic [3:0] OP_SAMPLE   = 4'b0001;
  localparam logic [3:0] OP_INTEST   = 4'b0010;
  localparam logic [3:0] OP_RUNBIST  = 4'b0011;
  localparam logic [3:0] OP_CLAMP    = 4'b0100;
  localparam logic [3:0] OP_HIGHZ    = 4'b0101;
  localparam logic [3:0] OP_USERCODE = 4'b1101;
  localparam logic [3:0] OP_IDCODE   = 4'b1110;
  localparam logic [3:0] OP_BYPASS   = 4'b1111;

  // Bit position of each instruction in SELECT.
  typedef enum logic [3:0] {
    SEL_BYPASS   = 4'd0,
    SEL_SAMPLE   = 4'd1,
    SEL_EXTEST   = 4'd2,
    SEL_INTEST   = 4'd3,
    SEL_RUNBIST  = 4'd4,
    SEL_CLAMP    = 4'd5,
    SEL_IDCODE   = 4'd6,
    SEL_USERCODE = 4'd7,
    SEL_HIGHZ    = 4'd8
  } sel_e;

  function automatic logic [NUM_INSTR-1:0] sel_onehot(input sel_e s);
    logic [NUM_INSTR-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/tap_ir_decode.sv
// ---------------------------------------------------------------------------
// tap_ir_decode
// Combinational instruction decoder: IR value in, one-hot select and
// "unknown opcode" flag out. Never produces an all-zero select: anything
// unrecognised falls back to BYPASS.
// Optional feature (macro TAP_IR_LOCK_EN): while i_lock is high, INTEST,
// RUNBIST and USERCODE are refused (BYPASS + invalid). Without the macro
// i_lock is ignored.
// Ports:
//   i_ir      [IR_WIDTH]   instruction value to decode
//   i_lock    [1]          instruction lock request
//   o_select  [NUM_INSTR]  one-hot select
//   o_invalid [1]          opcode not recognised (or refused by lock)
// ---------------------------------------------------------------------------
module tap_ir_decode
  import tap_pkg::*;
#(
  parameter int IR_WIDTH = 4
) (
  input  logic [IR_WIDTH-1:0]  i_ir,
  input  logic                 i_lock,
  output logic [NUM_INSTR-1:0] o_select,
  output logic                 o_invalid
);

  logic w_upper_zero;
  logic w_locked;

  // Short opcodes are only honoured when every bit above the low nibble is 0.
  assign w_upper_zero = ((i_ir >> 4) == '0);

`ifdef TAP_IR_LOCK_EN
  assign w_locked = i_lock;
`else
  logic w_unused_lock;
  assign w_unused_lock = i_lock;
  assign w_locked      = 1'b0;
`endif

  always_comb begin
    o_select  = sel_onehot(SEL_BYPASS);
    o_invalid = 1'b0;
    if (&i_ir) begin
      o_select = sel_onehot(SEL_BYPASS);
    end else if (!w_upper_zero) begin
      o_invalid = 1'b1;
    end else begin
      case (i_ir[3:0])
        OP_EXTEST:  o_select = sel_onehot(SEL_EXTEST);
        OP_SAMPLE:  o_select = sel_onehot(SEL_SAMPLE);
        OP_CLAMP:   o_select = sel_onehot(SEL_CLAMP);
        OP_HIGHZ:   o_select = sel_onehot(SEL_HIGHZ);
        OP_IDCODE:  o_select = sel_onehot(SEL_IDCODE);
        OP_BYPASS:  o_select = sel_onehot(SEL_BYPASS);
        OP_INTEST: begin
          if (w_locked) o_invalid = 1'b1;
          else          o_select  = sel_onehot(SEL_INTEST);
        end
        OP_RUNBIST: begin
          if (w_locked) o_invalid = 1'b1;
          else          o_select  = sel_onehot(SEL_RUNBIST);
        end
        OP_USERCODE: begin
          if (w_locked) o_invalid = 1'b1;
          else          o_select  = sel_onehot(SEL_USERCODE);
        end
        default:    o_invalid = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/tap_ir_ctrl.sv
// ---------------------------------------------------------------------------
// tap_ir_ctrl
// JTAG instruction register: capture/shift register (SR) plus latched
// instruction (LIR), with registered one-hot decode.
// Optional feature macro: TAP_IR_LOCK_EN (see tap_ir_decode).
// Ports:
//   TCK               clock, rising edge
//   TRST_N            asynchronous active-low reset
//   TDI               serial data in
//   TEST_LOGIC_RESET  TAP FSM in Test-Logic-Reset (synchronous)
//   CAPTURE_IR        TAP FSM in Capture-IR
//   SHIFT_IR          TAP FSM in Shift-IR
//   UPDATE_IR         TAP FSM in Update-IR
//   STATUS            loaded above the fixed 2'b01 pattern on capture
//   LOCK              instruction lock request
//   IR_TDO            serial out, SR bit 0
//   LATCHED_IR        current instruction (raw)
//   SELECT            one-hot instruction select (tap_pkg::sel_e order)
//   INVALID           one-cycle pulse after an unknown opcode is updated
// ---------------------------------------------------------------------------
module tap_ir_ctrl
  import tap_pkg::*;
#(
  parameter int IR_WIDTH     = 4,
  parameter int STATUS_WIDTH = IR_WIDTH - 2
) (
  input  logic                    TCK,
  input  logic                    TRST_N,
  input  logic                    TDI,
  input  logic                    TEST_LOGIC_RESET,
  input  logic                    CAPTURE_IR,
  input  logic                    SHIFT_IR,
  input  logic                    UPDATE_IR,
  input  logic [STATUS_WIDTH-1:0] STATUS,
  input  logic                    LOCK,
  output logic                    IR_TDO,
  output logic [IR_WIDTH-1:0]     LATCHED_IR,
  output logic [NUM_INSTR-1:0]    SELECT,
  output logic                    INVALID
);

  localparam int CAP_W = STATUS_WIDTH + 2;
  localparam logic [IR_WIDTH-1:0] LIR_RESET = IR_WIDTH'(OP_IDCODE);

  logic [IR_WIDTH-1:0]  r_sr;
  logic [IR_WIDTH-1:0]  r_lir;
  logic [NUM_INSTR-1:0] r_select;
  logic                 r_invalid;

  logic [CAP_W-1:0]     w_cap_full;
  logic [IR_WIDTH-1:0]  w_cap;
  logic [NUM_INSTR-1:0] w_select;
  logic                 w_invalid;

  // Capture pattern, zero-padded or truncated to the IR length.
  assign w_cap_full = {STATUS, 2'b01};

  generate
    for (genvar gi = 0; gi < IR_WIDTH; gi++) begin : g_cap
      if (gi < CAP_W) begin : g_bit
        assign w_cap[gi] = w_cap_full[gi];
      end else begin : g_pad
        assign w_cap[gi] = 1'b0;
      end
    end
  endgenerate

  // Decode the value about to be latched so SELECT/INVALID change on the
  // same edge as LATCHED_IR.
  tap_ir_decode #(
    .IR_WIDTH (IR_WIDTH)
  ) u_decode (
    .i_ir      (r_sr),
    .i_lock    (LOCK),
    .o_select  (w_select),
    .o_invalid (w_invalid)
  );

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_sr      <= '0;
      r_lir     <= LIR_RESET;
      r_select  <= sel_onehot(SEL_IDCODE);
      r_invalid <= 1'b0;
    end else begin
      r_invalid <= 1'b0;
      if (TEST_LOGIC_RESET) begin
        r_lir    <= LIR_RESET;
        r_select <= sel_onehot(SEL_IDCODE);
      end else if (UPDATE_IR) begin
        r_lir     <= r_sr;
        r_select  <= w_select;
        r_invalid <= w_invalid;
      end else if (CAPTURE_IR) begin
        r_sr <= w_cap;
      end else if (SHIFT_IR) begin
        r_sr <= {TDI, r_sr[IR_WIDTH-1:1]};
      end
    end
  end

  assign IR_TDO     = r_sr[0];
  assign LATCHED_IR = r_lir;
  assign SELECT     = r_select;
  assign INVALID    = r_invalid;

endmodule

// File: tb/tb_tap_ir_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tap_ir_ctrl
// Directed bench: one 4-bit and one 6-bit instance share the TAP strobes and
// TDI; expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_tap_ir_ctrl;
  import tap_pkg::*;

  logic       TCK;
  logic       TRST_N;
  logic       TDI;
  logic       TEST_LOGIC_RESET;
  logic       CAPTURE_IR;
  logic       SHIFT_IR;
  logic       UPDATE_IR;
  logic       LOCK;
  logic [1:0] status_4;
  logic [3:0] status_6;

  logic       tdo_4;
  logic [3:0] lir_4;
  logic [8:0] sel_4;
  logic       inv_4;
  logic       tdo_6;
  logic [5:0] lir_6;
  logic [8:0] sel_6;
  logic       inv_6;

  int n_checks;
  int n_errors;

  tap_ir_ctrl #(.IR_WIDTH(4)) u_dut4 (
    .TCK              (TCK),
    .TRST_N           (TRST_N),
    .TDI              (TDI),
    .TEST_LOGIC_RESET (TEST_LOGIC_RESET),
    .CAPTURE_IR       (CAPTURE_IR),
    .SHIFT_IR         (SHIFT_IR),
    .UPDATE_IR        (UPDATE_IR),
    .STATUS           (status_4),
    .LOCK             (LOCK),
    .IR_TDO           (tdo_4),
    .LATCHED_IR       (lir_4),
    .SELECT           (sel_4),
    .INVALID          (inv_4)
  );

  tap_ir_ctrl #(.IR_WIDTH(6)) u_dut6 (
    .TCK              (TCK),
    .TRST_N           (TRST_N),
    .TDI              (TDI),
    .TEST_LOGIC_RESET (TEST_LOGIC_RESET),
    .CAPTURE_IR       (CAPTURE_IR),
    .SHIFT_IR         (SHIFT_IR),
    .UPDATE_IR        (UPDATE_IR),
    .STATUS           (status_6),
    .LOCK             (LOCK),
    .IR_TDO           (tdo_6),
    .LATCHED_IR       (lir_6),
    .SELECT           (sel_6),
    .INVALID          (inv_6)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s value=0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge TCK);
    #1;
  endtask

  // Shift n bits of v into the IR, LSB first.
  task automatic shift_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      TDI      = v[i];
      SHIFT_IR = 1'b1;
      tick();
    end
    SHIFT_IR = 1'b0;
    TDI      = 1'b0;
  endtask

  task automatic do_update();
    UPDATE_IR = 1'b1;
    tick();
    UPDATE_IR = 1'b0;
  endtask

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    TRST_N           = 1'b1;
    TDI              = 1'b0;
    TEST_LOGIC_RESET = 1'b0;
    CAPTURE_IR       = 1'b0;
    SHIFT_IR         = 1'b0;
    UPDATE_IR        = 1'b0;
    LOCK             = 1'b0;
    status_4         = 2'b10;
    status_6         = 4'b0000;

    // Asynchronous reset, observed before any clock edge.
    #1 TRST_N = 1'b0;
    #1;
    check("rst_lir4", 32'(lir_4), 32'h0E);
    check("rst_sel4", 32'(sel_4), 32'h040);
    check("rst_tdo4", 32'(tdo_4), 32'h0);
    check("rst_inv4", 32'(inv_4), 32'h0);
    check("rst_lir6", 32'(lir_6), 32'h0E);
    #5 TRST_N = 1'b1;

    // Capture STATUS=10 -> SR=1001, then shift zeros: TDO 1,0,0,1.
    CAPTURE_IR = 1'b1;
    tick();
    CAPTURE_IR = 1'b0;
    check("cap_tdo0", 32'(tdo_4), 32'h1);
    check("cap6_tdo0", 32'(tdo_6), 32'h1);
    TDI      = 1'b0;
    SHIFT_IR = 1'b1;
    tick();
    check("cap_tdo1", 32'(tdo_4), 32'h0);
    tick();
    check("cap_tdo2", 32'(tdo_4), 32'h0);
    tick();
    check("cap_tdo3", 32'(tdo_4), 32'h1);
    tick();
    SHIFT_IR = 1'b0;
    check("cap_tdo4", 32'(tdo_4), 32'h0);
    check("sel_hold", 32'(sel_4), 32'h040);

    // All ones -> BYPASS. The 6-bit IR now holds 111100 (unknown).
    shift_bits(16'h000F, 4);
    do_update();
    check("byp_sel4", 32'(sel_4), 32'h001);
    check("byp_inv4", 32'(inv_4), 32'h0);
    check("byp_lir4", 32'(lir_4), 32'hF);
    check("unk_inv6", 32'(inv_6), 32'h1);
    check("unk_lir6", 32'(lir_6), 32'h3C);

    // 010010 on the 6-bit IR: nonzero upper bits -> BYPASS + one INVALID pulse.
    // The 4-bit IR keeps the last four bits 0100 = CLAMP.
    shift_bits(16'h0012, 6);
    do_update();
    check("w6_lir6", 32'(lir_6), 32'h12);
    check("w6_sel6", 32'(sel_6), 32'h001);
    check("w6_inv6", 32'(inv_6), 32'h1);
    check("clamp_sel4", 32'(sel_4), 32'h020);
    check("clamp_inv4", 32'(inv_4), 32'h0);
    tick();
    check("w6_inv6_end", 32'(inv_6), 32'h0);
    check("w6_lir6_hold", 32'(lir_6), 32'h12);
    check("w6_sel6_hold", 32'(sel_6), 32'h001);

    // INTEST, unlocked then locked.
    LOCK = 1'b0;
    shift_bits(16'h0002, 4);
    do_update();
    check("intest_sel4", 32'(sel_4), 32'h008);
    check("intest_inv4", 32'(inv_4), 32'h0);
    LOCK = 1'b1;
    shift_bits(16'h0002, 4);
    do_update();
    check("lock_lir4", 32'(lir_4), 32'h2);
`ifdef TAP_IR_LOCK_EN
    check("lock_sel4", 32'(sel_4), 32'h001);
    check("lock_inv4", 32'(inv_4), 32'h1);
`else
    check("lock_sel4", 32'(sel_4), 32'h008);
    check("lock_inv4", 32'(inv_4), 32'h0);
`endif
    LOCK = 1'b0;

    // TEST_LOGIC_RESET wins over UPDATE_IR; SR untouched.
    shift_bits(16'h000F, 4);
    UPDATE_IR        = 1'b1;
    TEST_LOGIC_RESET = 1'b1;
    tick();
    UPDATE_IR        = 1'b0;
    TEST_LOGIC_RESET = 1'b0;
    check("tlr_sel4", 32'(sel_4), 32'h040);
    check("tlr_lir4", 32'(lir_4), 32'hE);
    check("tlr_inv4", 32'(inv_4), 32'h0);
    check("tlr_tdo4", 32'(tdo_4), 32'h1);
    do_update();
    check("tlr_sr_kept", 32'(lir_4), 32'hF);

    // TRST_N pulse mid-shift: SR 1111 -> 0011 then cleared asynchronously.
    TDI      = 1'b0;
    SHIFT_IR = 1'b1;
    tick();
    tick();
    check("mid_tdo", 32'(tdo_4), 32'h1);
    #2 TRST_N = 1'b0;
    #1;
    check("trst_tdo4", 32'(tdo_4), 32'h0);
    check("trst_lir4", 32'(lir_4), 32'hE);
    check("trst_sel4", 32'(sel_4), 32'h040);
    SHIFT_IR = 1'b0;
    #1 TRST_N = 1'b1;
    do_update();
    check("trst_sr_zero", 32'(lir_4), 32'h0);
    check("trst_extest", 32'(sel_4), 32'h004);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tap_ir_ctrl.md
TAP_IR_CTRL -- requirements
Module: tap_ir_ctrl

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 4, instruction register length in bits; legal range 4..16.
REQ-002 SHALL have parameter STATUS_WIDTH, default IR_WIDTH-2, width of the STATUS capture input.
REQ-003 SHALL have ports:
  - TCK  input  1  sole clock; all state changes on rising edge.
  - TRST_N  input  1  reset, asynchronous, active-low.
  - TDI  input  1  serial data in.
  - TEST_LOGIC_RESET  input  1  synchronous TAP-FSM reset state.
  - CAPTURE_IR  input  1  Capture-IR state.
  - SHIFT_IR  input  1  Shift-IR state.
  - UPDATE_IR  input  1  Update-IR state.
  - STATUS  input  STATUS_WIDTH  captured into upper IR bits.
  - LOCK  input  1  restricts instructions (REQ-019).
  - IR_TDO  output  1  serial data out (shift register bit 0).
  - LATCHED_IR  output  IR_WIDTH  current instruction.
  - SELECT  output  9  one-hot instruction select, bit order per package enum.
  - INVALID  output  1  one-cycle pulse: last update decoded to an unknown opcode.

Function
REQ-004 SHALL hold an IR_WIDTH-bit shift register (SR) and a latched register (LIR).
REQ-005 CAPTURE_IR: SR <= {STATUS, 2'b01}, zero-padded/truncated to IR_WIDTH.
REQ-006 SHIFT_IR: SR <= {TDI, SR[IR_WIDTH-1:1]}; LSB first out.
REQ-007 UPDATE_IR: LIR <= SR; SELECT and INVALID registered on the same edge (visible the cycle after UPDATE_IR is sampled high).
REQ-008 Priority when asserted together: TEST_LOGIC_RESET > UPDATE_IR > CAPTURE_IR > SHIFT_IR.
REQ-009 TEST_LOGIC_RESET high: LIR <= IDCODE, SELECT <= IDCODE one-hot, INVALID <= 0, SR unchanged.
REQ-010 No strobe high: SR, LIR, SELECT hold; INVALID <= 0.
REQ-011 IR_TDO = SR[0], combinational from register only.
REQ-012 Decode: all-ones LIR -> BYPASS at any IR_WIDTH.
REQ-013 Other opcodes match only when LIR[IR_WIDTH-1:4] == 0 and LIR[3:0] equals a package code.
REQ-014 Unmatched opcode -> BYPASS select and INVALID=1 for exactly one cycle; LATCHED_IR still shows the raw value.
REQ-015 SELECT SHALL be exactly one-hot at all times after reset.

Reset
REQ-016 TRST_N low: SR <= all zero, LATCHED_IR <= IDCODE (zero-extended), SELECT <= IDCODE one-hot, INVALID <= 0, immediately, regardless of TCK.
REQ-017 Reset mid-shift aborts the shift; no partial SR value is ever updated into LIR.
REQ-018 Release of TRST_N SHALL take effect at the next TCK rising edge; no output glitch on release.

Configuration
REQ-019 Macro TAP_IR_LOCK_EN defined: when LOCK=1 at update, INTEST, RUNBIST and USERCODE decode to BYPASS with INVALID=1; LATCHED_IR keeps the raw value.
REQ-020 Macro TAP_IR_LOCK_EN undefined: LOCK is ignored and REQ-019 logic is absent; the port remains.

Structure
REQ-021 Shared package tap_pkg SHALL hold: 4-bit opcode constants (BYPASS, SAMPLE, EXTEST, INTEST, RUNBIST, CLAMP, IDCODE, USERCODE, HIGHZ), the SELECT index enum, and the constant NUM_INSTR = 9.
REQ-022 Decode SHALL be a sub-module tap_ir_decode: combinational, LIR in -> SELECT/INVALID out; registered in tap_ir_ctrl.

Verification
REQ-023 Assert TRST_N=0 -> LATCHED_IR=4'b1110 (IDCODE), SELECT=IDCODE only, IR_TDO=0.
REQ-024 IR_WIDTH=4: capture with STATUS=2'b10, shift 4 cycles with TDI=0 -> IR_TDO sequence 1,0,0,1.
REQ-025 Shift in 4'b1111, UPDATE_IR -> next cycle BYPASS_SELECT=1, INVALID=0.
REQ-026 IR_WIDTH=6: shift in 6'b010010, update -> BYPASS selected, INVALID high for exactly one cycle, LATCHED_IR=6'b010010.
REQ-027 UPDATE_IR and TEST_LOGIC_RESET high on the same edge -> IDCODE selected; TRST_N pulse mid-shift -> IDCODE, SR=0.
REQ-028 With TAP_IR_LOCK_EN and LOCK=1: update with INTEST -> BYPASS, INVALID pulse; with LOCK=0 -> INTEST selected.
